// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target that models a camera register port.
// Oversamples sioc/siod on clk, decodes START/STOP, 3-phase writes
// (id, reg, value) and 2-phase-write + read, and exposes register
// accesses through one-clk write/read strobes.
// Build option: define SCCB_TARGET_ACK_EN to actively drive the ACK bit
// after each byte of a matched transaction; otherwise the 9th bit is
// left released (plain SCCB don't-care phase).
module sccb_target #(
    parameter logic [7:0]  DEV_ID      = 8'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       busy,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data
);

`ifdef SCCB_TARGET_ACK_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_REG,
        S_REG_ACK,
        S_DATA,
        S_DATA_ACK,
        S_RD_LOAD,
        S_RD_BYTE,
        S_RD_NACK,
        S_WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sioc_sync_q;
    logic [SYNC_STAGES-1:0] siod_sync_q;
    logic                   sioc_prev_q;
    logic                   siod_prev_q;
    logic                   sioc_s;
    logic                   siod_s;
    logic                   sioc_rise;
    logic                   sioc_fall;
    logic                   start_det;
    logic                   stop_det;

    // Synchronizers reset to the idle-bus level so reset never fakes a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_in};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_in};
            sioc_prev_q <= sioc_sync_q[SYNC_STAGES-1];
            siod_prev_q <= siod_sync_q[SYNC_STAGES-1];
        end
    end

    assign sioc_s    = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s    = siod_sync_q[SYNC_STAGES-1];
    assign sioc_rise = sioc_s & ~sioc_prev_q;
    assign sioc_fall = ~sioc_s & sioc_prev_q;
    assign start_det = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
    assign stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;

    // ------------------------------------------------------------------
    // Protocol FSM and datapath registers
    // ------------------------------------------------------------------
    state_t     state_q,   state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] ptr_q,     ptr_d;
    logic       rw_q,      rw_d;
    logic       ack_on_q,  ack_on_d;
    logic       oe_q,      oe_d;
    logic       busy_q,    busy_d;
    logic       wr_en_q,   wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_req_q,  rd_req_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q[6:0], siod_s};

    // State and datapath register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_on_q  <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_on_q  <= ack_on_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_req_q  <= rd_req_d;
        end
    end

    // Next-state and output decode; STOP outranks START, both outrank the state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_on_d  = ack_on_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_req_d  = 1'b0;

        if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            ack_on_d  = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = S_ID;
            bit_cnt_d = '0;
            ack_on_d  = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    oe_d = 1'b0;
                end

                S_ID: begin
                    if (sioc_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ID[7:1]) begin
                                rw_d    = rx_byte[0];
                                state_d = S_ID_ACK;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end

                // ACK phases span two sioc falls: the first opens the 9th bit,
                // the second closes it. A read leaves on the first fall so the
                // register fetch overlaps the ACK bit.
                S_ID_ACK: begin
                    if (sioc_fall) begin
                        if (!ack_on_q) begin
                            oe_d = ACK_DRIVE;
                            if (rw_q) begin
                                rd_req_d = 1'b1;
                                state_d  = S_RD_LOAD;
                            end else begin
                                ack_on_d = 1'b1;
                            end
                        end else begin
                            oe_d      = 1'b0;
                            ack_on_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_REG;
                        end
                    end
                end

                S_REG: begin
                    if (sioc_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d   = rx_byte;
                            state_d = S_REG_ACK;
                        end
                    end
                end

                S_REG_ACK: begin
                    if (sioc_fall) begin
                        if (!ack_on_q) begin
                            oe_d     = ACK_DRIVE;
                            ack_on_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            ack_on_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (sioc_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            state_d   = S_DATA_ACK;
                        end
                    end
                end

                S_DATA_ACK: begin
                    if (sioc_fall) begin
                        if (!ack_on_q) begin
                            oe_d     = ACK_DRIVE;
                            ack_on_d = 1'b1;
                        end else begin
                            oe_d     = 1'b0;
                            ack_on_d = 1'b0;
                            state_d  = S_WAIT_STOP;
                        end
                    end
                end

                // rd_data arrives the clk after rd_req; the fall that ends the
                // ACK bit then presents the MSB.
                S_RD_LOAD: begin
                    if (sioc_fall) begin
                        oe_d      = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = '0;
                        state_d   = S_RD_BYTE;
                    end else if (rd_req_q) begin
                        shift_d = rd_data;
                    end
                end

                S_RD_BYTE: begin
                    if (sioc_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_RD_NACK;
                        end
                    end else if (sioc_fall) begin
                        oe_d    = ~shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end

                // Single-byte reads only: master ACK or NA both end the transfer.
                S_RD_NACK: begin
                    if (sioc_fall) begin
                        oe_d = 1'b0;
                    end else if (sioc_rise) begin
                        state_d = S_WAIT_STOP;
                    end
                end

                S_WAIT_STOP: begin
                    oe_d = 1'b0;
                end

                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign siod_oe = oe_q;
    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_req  = rd_req_q;
    assign rd_addr = ptr_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target acting as an SCCB master
// with an open-drain siod bus.
module tb_sccb_target;

    localparam int Q = 8;  // clk cycles per quarter sioc period

`ifdef SCCB_TARGET_ACK_EN
    localparam int ACK_CYC = 4 * Q;
`else
    localparam int ACK_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sioc_m;
    logic       siod_m;
    logic       siod_bus;
    logic       siod_oe;
    logic       busy;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data_tb;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cyc = 0;
    logic [7:0] mon_rd_addr = '0;

    assign siod_bus = siod_m & ~siod_oe;

    always #5 clk = ~clk;

    sccb_target #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .sioc_in (sioc_m),
        .siod_in (siod_bus),
        .siod_oe (siod_oe),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data_tb)
    );

    // Strobe/oe monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en)   wr_cnt <= wr_cnt + 1;
        if (rd_req) begin
            rd_cnt      <= rd_cnt + 1;
            mon_rd_addr <= rd_addr;
        end
        if (siod_oe) oe_cyc <= oe_cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        siod_m = 1'b1; wait_q();
        sioc_m = 1'b1; wait_q();
        siod_m = 1'b0; wait_q();
        sioc_m = 1'b0; wait_q();
    endtask

    task automatic m_bit(input logic b);
        siod_m = b;    wait_q();
        sioc_m = 1'b1; wait_q(); wait_q();
        sioc_m = 1'b0; wait_q();
    endtask

    // 8 data bits MSB first, then a released 9th (ACK) bit.
    task automatic m_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_bit(1'b1);
    endtask

    task automatic m_stop();
        siod_m = 1'b0; wait_q();
        sioc_m = 1'b1; wait_q();
        siod_m = 1'b1; wait_q(); wait_q();
    endtask

    // Read one byte with siod released, then send NA.
    task automatic m_read(output logic [7:0] b);
        b = '0;
        siod_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_q();
            sioc_m = 1'b1; wait_q();
            b = {b[6:0], siod_bus}; wait_q();
            sioc_m = 1'b0; wait_q();
        end
        m_bit(1'b1);
    endtask

    typedef struct {
        logic [7:0] id;
        logic [7:0] rg;
        logic [7:0] dat;
        int         exp_wr;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_oe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int wr0;
        int rd0;
        logic [7:0] rb;

        vecs[0] = '{8'h42, 8'h12, 8'h80, 1, 8'h12, 8'h80, 3 * ACK_CYC};
        vecs[1] = '{8'h60, 8'h12, 8'h80, 0, 8'h12, 8'h80, 0};
        vecs[2] = '{8'h42, 8'hFF, 8'h00, 1, 8'hFF, 8'h00, 3 * ACK_CYC};
        vecs[3] = '{8'hC2, 8'h55, 8'h66, 0, 8'hFF, 8'h00, 0};
        vecs[4] = '{8'h42, 8'h00, 8'hFF, 1, 8'h00, 8'hFF, 3 * ACK_CYC};
        vecs[5] = '{8'h40, 8'h77, 8'h99, 0, 8'h00, 8'hFF, 0};

        rst = 1'b1; sioc_m = 1'b1; siod_m = 1'b1; rd_data_tb = 8'h76;
        repeat (5) @(negedge clk);
        chk("rst_oe",     siod_oe, 0);
        chk("rst_busy",   busy,    0);
        chk("rst_wr_en",  wr_en,   0);
        chk("rst_rd_req", rd_req,  0);
        chk("rst_wraddr", wr_addr, 0);
        chk("rst_wrdata", wr_data, 0);
        chk("rst_rdaddr", rd_addr, 0);
        rst = 1'b0;
        wait_q();

        // Table-driven 3-phase writes
        foreach (vecs[k]) begin
            wr0 = wr_cnt;
            oe_cyc = 0;
            m_start();
            chk($sformatf("v%0d_busy_on", k), busy, 1);
            m_byte(vecs[k].id);
            m_byte(vecs[k].rg);
            m_byte(vecs[k].dat);
            m_stop();
            chk($sformatf("v%0d_wr_cnt", k), wr_cnt - wr0, vecs[k].exp_wr);
            chk($sformatf("v%0d_wr_addr", k), wr_addr, vecs[k].exp_addr);
            chk($sformatf("v%0d_wr_data", k), wr_data, vecs[k].exp_data);
            chk($sformatf("v%0d_oe_cyc", k), oe_cyc, vecs[k].exp_oe);
            chk($sformatf("v%0d_busy_off", k), busy, 0);
            wait_q();
        end

        // Pointer write then read
        wr0 = wr_cnt;
        m_start(); m_byte(8'h42); m_byte(8'h0A); m_stop();
        chk("ptr_no_wr", wr_cnt - wr0, 0);
        chk("ptr_rdaddr", rd_addr, 8'h0A);
        wait_q();
        rd0 = rd_cnt;
        m_start(); m_byte(8'h43); m_read(rb); m_stop();
        chk("rd_req_cnt", rd_cnt - rd0, 1);
        chk("rd_req_addr", mon_rd_addr, 8'h0A);
        chk("rd_byte", rb, 8'h76);
        chk("rd_busy_off", busy, 0);
        chk("rd_oe_off", siod_oe, 0);
        wait_q();

        // Repeated START keeps the pointer and drops the first transaction
        wr0 = wr_cnt;
        m_start(); m_byte(8'h42); m_byte(8'h12);
        m_start();
        chk("rs_ptr_kept", rd_addr, 8'h12);
        chk("rs_busy", busy, 1);
        m_byte(8'h42); m_byte(8'h34); m_byte(8'h55); m_stop();
        chk("rs_wr_cnt", wr_cnt - wr0, 1);
        chk("rs_wr_addr", wr_addr, 8'h34);
        chk("rs_wr_data", wr_data, 8'h55);
        wait_q();

        // Partial data byte discarded by STOP, then a full write works
        wr0 = wr_cnt;
        m_start(); m_byte(8'h42); m_byte(8'h12);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b0);
        m_stop();
        chk("part_no_wr", wr_cnt - wr0, 0);
        wait_q();
        m_start(); m_byte(8'h42); m_byte(8'h01); m_byte(8'hAA); m_stop();
        chk("part_next_cnt", wr_cnt - wr0, 1);
        chk("part_next_addr", wr_addr, 8'h01);
        chk("part_next_data", wr_data, 8'hAA);
        wait_q();

        // Reset while sioc is high during DATA bit 5
        wr0 = wr_cnt;
        m_start(); m_byte(8'h42); m_byte(8'h03);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b0);
        siod_m = 1'b1; wait_q();
        sioc_m = 1'b1; wait_q();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_oe",     siod_oe, 0);
        chk("mrst_busy",   busy,    0);
        chk("mrst_wr_en",  wr_en,   0);
        chk("mrst_rd_req", rd_req,  0);
        chk("mrst_wraddr", wr_addr, 0);
        chk("mrst_wrdata", wr_data, 0);
        chk("mrst_rdaddr", rd_addr, 0);
        rst = 1'b0;
        wait_q(); wait_q();
        chk("mrst_no_wr", wr_cnt - wr0, 0);
        m_start(); m_byte(8'h42); m_byte(8'h03); m_byte(8'h11); m_stop();
        chk("mrst_next_cnt", wr_cnt - wr0, 1);
        chk("mrst_next_addr", wr_addr, 8'h03);
        chk("mrst_next_data", wr_data, 8'h11);
        chk("mrst_busy_off", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
